bcd_stopwatch_counter: RTL

Parametrised N-digit BCD stopwatch core: counts up or down at a configurable tick period under play/pause/clear control, with wrap or saturate at the count limit and an optional lap-hold display freeze. Sits between the debounce_module instances on the push-buttons and the per-digit binary_to_7_segment encoders. Replaces fixed two-digit counters in board top levels.

---
 rtl/bcd_stopwatch_counter_pkg.sv | 20 ++
 rtl/bcd_stopwatch_counter_bcd_digit.sv | 35 +++
 rtl/bcd_stopwatch_counter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_stopwatch_counter_pkg.sv
// Shared state encodings, BCD constants and helpers for the BCD stopwatch.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bcd_stopwatch_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    // A digit sits at its limit when it is about to carry (up) or borrow (down).
    function automatic logic digit_at_limit(input logic [3:0] d, input logic down);
        return down ? (d == BCD_MIN) : (d == BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_stopwatch_counter_bcd_digit.sv
// One decade up/down counter; carry/borrow chained digit to digit.
// Latency: value updates on the clock edge where step and carry_in are both high.
// Backpressure: none; steps are accepted every cycle.
module bcd_digit
    import bcd_stopwatch_counter_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       clr,
    input  logic       step,
    input  logic       down,
    input  logic       carry_in,
    output logic [3:0] digit,
    output logic       carry_out
);

    // Ripple out only when every lower digit (via carry_in) and this one are at limit.
    assign carry_out = carry_in & digit_at_limit(digit, down);

    // Decade count: 9 -> 0 going up, 0 -> 9 going down; 10..15 are unreachable.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            digit <= BCD_MIN;
        end else if (clr) begin
            digit <= BCD_MIN;
        end else if (step && carry_in) begin
            if (down) begin
                digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
            end else begin
                digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_stopwatch_counter.sv
// N-digit BCD stopwatch with play/pause/clear, up/down, wrap or saturate; lap hold under STOPWATCH_LAP_EN.
// Latency: button presses act on the edge they are sampled; outputs are registered (visible next cycle).
// Backpressure: none; free-running core, buttons are level inputs edge-detected internally.
module bcd_stopwatch_counter
    import bcd_stopwatch_counter_pkg::*;
#(
    parameter int NUM_DIGITS      = 4,
    parameter int TICKS_PER_COUNT = 25000000,
    parameter int SATURATE        = 0
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic                    i_Start_Stop,
    input  logic                    i_Clear,
    input  logic                    i_Lap,
    input  logic                    i_Down,
    output logic [4*NUM_DIGITS-1:0] o_Digits,
    output logic                    o_Running,
    output logic                    o_Wrap,
    output logic                    o_Lap_Hold
);

    localparam int TICK_W = $clog2(TICKS_PER_COUNT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_COUNT - 1);

    sw_state_t               state;
    logic [TICK_W-1:0]       tick_q;
    logic                    start_prev;
    logic                    clear_prev;
    logic                    running_q;
    logic                    wrap_q;
    logic [4*NUM_DIGITS-1:0] count_q;
    logic [NUM_DIGITS:0]     carry;

    logic start_p;
    logic clear_p;
    logic step_ok;
    logic at_limit;
    logic near_limit;
    logic count_step;
    logic count_clr;

    // Previous-level registers reset high so a button held through reset is not a press.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            start_prev <= 1'b1;
            clear_prev <= 1'b1;
        end else begin
            start_prev <= i_Start_Stop;
            clear_prev <= i_Clear;
        end
    end

    assign start_p = i_Start_Stop & ~start_prev;
    assign clear_p = i_Clear & ~clear_prev;

    // A step is due on the last tick of a period in RUN; clear on the same edge cancels it.
    assign step_ok    = (state == ST_RUN) && (tick_q == TICK_LAST) && !clear_p;
    assign at_limit   = carry[NUM_DIGITS];
    assign count_step = step_ok && !((SATURATE != 0) && at_limit);
    assign count_clr  = clear_p || (state == ST_IDLE);

    // One step away from the limit: digit 0 is 8 (up) or 1 (down), all higher digits already at limit.
    always_comb begin
        near_limit = (count_q[3:0] == (i_Down ? (BCD_MIN + 4'd1) : (BCD_MAX - 4'd1)));
        for (int k = 1; k < NUM_DIGITS; k++) begin
            near_limit = near_limit & digit_at_limit(count_q[4*k +: 4], i_Down);
        end
    end

    // Tick counter: zero in IDLE or on clear, frozen in PAUSE, free-running modulo period in RUN.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            tick_q <= '0;
        end else if (clear_p || (state == ST_IDLE)) begin
            tick_q <= '0;
        end else if (state == ST_RUN) begin
            tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
        end
    end

    // Control FSM with registered running and wrap flags; clear beats start in every state.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= ST_IDLE;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            if (SATURATE != 0) begin
                wrap_q <= step_ok && !at_limit && near_limit;
            end else begin
                wrap_q <= step_ok && at_limit;
            end
            case (state)
                ST_IDLE: begin
                    if (start_p && !clear_p) begin
                        state     <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clear_p) begin
                        state     <= ST_IDLE;
                        running_q <= 1'b0;
                    end else if (start_p || (step_ok && (SATURATE != 0) && at_limit)) begin
                        state     <= ST_PAUSE;
                        running_q <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (clear_p) begin
                        state     <= ST_IDLE;
                        running_q <= 1'b0;
                    end else if (start_p) begin
                        state     <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign carry[0] = 1'b1;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .i_Clk     (i_Clk),
            .i_Rst_L   (i_Rst_L),
            .clr       (count_clr),
            .step      (count_step),
            .down      (i_Down),
            .carry_in  (carry[k]),
            .digit     (count_q[4*k +: 4]),
            .carry_out (carry[k+1])
        );
    end

    assign o_Running = running_q;
    assign o_Wrap    = wrap_q;

`ifdef STOPWATCH_LAP_EN
    logic                    lap_prev;
    logic                    hold_q;
    logic [4*NUM_DIGITS-1:0] lap_q;
    logic                    lap_p;

    assign lap_p = i_Lap & ~lap_prev;

    // Lap hold: snapshot in RUN, any later lap press releases, clear releases.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            lap_prev <= 1'b1;
            hold_q   <= 1'b0;
            lap_q    <= '0;
        end else begin
            lap_prev <= i_Lap;
            if (clear_p) begin
                hold_q <= 1'b0;
            end else if (lap_p) begin
                if (hold_q) begin
                    hold_q <= 1'b0;
                end else if (state == ST_RUN) begin
                    hold_q <= 1'b1;
                    lap_q  <= count_q;
                end
            end
        end
    end

    assign o_Lap_Hold = hold_q;
    assign o_Digits   = hold_q ? lap_q : count_q;
`else
    logic lap_unused;
    assign lap_unused = i_Lap;
    assign o_Lap_Hold = 1'b0;
    assign o_Digits   = count_q;
`endif

endmodule
